// File: rtl/counter_apb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// counter_apb_arbiter: round-robin APB master arbiter/sequencer, NUM_REQ requesters.
// Optional COUNTER_APB_ARB_PREADY_EN adds i_pready wait states.  Rev 1.0
// ---------------------------------------------------------------------------
module counter_apb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      i_pclk,
  input  logic                      i_prst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  input  logic [NUM_REQ-1:0]        i_req_write,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_paddr,
  output logic [DATA_W-1:0]         o_pwdata,
  output logic                      o_pwrite,
  output logic                      o_psel,
  output logic                      o_penable,
`ifdef COUNTER_APB_ARB_PREADY_EN
  input  logic                      i_pready,
`endif
  input  logic [DATA_W-1:0]         i_prdata
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_idx_w-1:0]   r_ptr, w_ptr_nxt;
  logic [c_idx_w-1:0]   r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]    r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]    r_pwdata, w_pwdata_nxt;
  logic                 r_pwrite, w_pwrite_nxt;
  logic                 r_psel, w_psel_nxt;
  logic                 r_penable, w_penable_nxt;
  logic                 r_busy, w_busy_nxt;

  logic                 w_ready;
  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_found;
  logic [c_idx_w-1:0]   w_win;
  logic [c_idx_w-1:0]   w_owner_inc;

`ifdef COUNTER_APB_ARB_PREADY_EN
  assign w_ready = i_pready;
`else
  assign w_ready = 1'b1;
`endif

  // A requester being acked this cycle still has its old request up; mask it.
  assign w_elig = i_req & ~r_ack;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_win   = c_idx_w'(j);
      end
    end
  end

  assign w_owner_inc = (r_owner == c_idx_w'(NUM_REQ - 1)) ? '0 : r_owner + c_idx_w'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_ack_nxt     = '0;
    w_grant_nxt   = r_grant;
    w_rdata_nxt   = r_rdata;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_busy_nxt    = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_SETUP;
          w_owner_nxt   = w_win;
          w_paddr_nxt   = i_req_addr[w_win*ADDR_W +: ADDR_W];
          w_pwdata_nxt  = i_req_wdata[w_win*DATA_W +: DATA_W];
          w_pwrite_nxt  = i_req_write[w_win];
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_grant_nxt   = NUM_REQ'(1) << w_win;
          w_busy_nxt    = 1'b1;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_ready) begin
          if (!r_pwrite) w_rdata_nxt = i_prdata;
          w_ack_nxt     = NUM_REQ'(1) << r_owner;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = w_owner_inc;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_grant_nxt   = '0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_ack     <= '0;
      r_grant   <= '0;
      r_rdata   <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_ack     <= w_ack_nxt;
      r_grant   <= w_grant_nxt;
      r_rdata   <= w_rdata_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_ack     = r_ack;
  assign o_rdata   = r_rdata;
  assign o_grant   = r_grant;
  assign o_busy    = r_busy;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
  assign o_pwrite  = r_pwrite;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_counter_apb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_counter_apb_arbiter: random requesters vs. a transfer-level reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_counter_apb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    write = '0;
  logic [DW-1:0]   prdata = '0;
  logic            pready = 1'b1;

  logic [N-1:0]    ack, grant;
  logic [DW-1:0]   rdata, pwdata;
  logic [AW-1:0]   paddr;
  logic            busy, pwrite, psel, penable;

  always #5 clk = ~clk;

  counter_apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_pclk      (clk),
    .i_prst_n    (rst_n),
    .i_req       (req),
    .i_req_addr  (addr),
    .i_req_wdata (wdata),
    .i_req_write (write),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .o_pwrite    (pwrite),
    .o_psel      (psel),
    .o_penable   (penable),
`ifdef COUNTER_APB_ARB_PREADY_EN
    .i_pready    (pready),
`endif
    .i_prdata    (prdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the transfer in flight (owner, cycles since grant) and
  // the requester acknowledged in the current cycle; -1 means none.
  int          m_owner, m_age, m_ack, m_ptr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_rdata;
  logic          m_pwrite;
  int            ag [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] oh(input int k);
    return (k < 0) ? 64'd0 : (64'd1 << k);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ack = -1; m_ptr = 0;
    m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_pwrite = 1'b0;
  endtask

  // Compare this cycle's outputs, then let the model consume this cycle's inputs.
  task automatic tick();
    logic [63:0] mask;
    logic [N-1:0] elig;
    logic rdy;
    int nack;
    @(negedge clk);
    check("psel",    psel,    m_owner >= 0);
    check("penable", penable, (m_owner >= 0) && (m_age >= 2));
    check("grant",   grant,   oh(m_owner));
    check("busy",    busy,    m_owner >= 0);
    check("ack",     ack,     oh(m_ack));
    check("rdata",   rdata,   m_rdata);
    check("paddr",   paddr,   m_paddr);
    check("pwdata",  pwdata,  m_pwdata);
    check("pwrite",  pwrite,  m_pwrite);
`ifdef COUNTER_APB_ARB_PREADY_EN
    rdy = pready;
`else
    rdy = 1'b1;
`endif
    nack = -1;
    if (m_owner >= 0) begin
      if (m_age >= 2 && rdy) begin
        if (!m_pwrite) m_rdata = prdata;
        nack    = m_owner;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      mask = oh(m_ack);
      elig = req & ~mask[N-1:0];
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (m_owner < 0 && elig[j]) begin
          m_owner  = j;
          m_age    = 1;
          m_paddr  = addr[j*AW +: AW];
          m_pwdata = wdata[j*DW +: DW];
          m_pwrite = write[j];
        end
      end
    end
    m_ack = nack;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_psel",    psel,    0);
    check("rst_penable", penable, 0);
    check("rst_grant",   grant,   0);
    check("rst_busy",    busy,    0);
    check("rst_ack",     ack,     0);
    check("rst_paddr",   paddr,   0);
    check("rst_rdata",   rdata,   0);
    model_reset();
    for (int k = 0; k < N; k++) if (ag[k] == 2) ag[k] = 0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1;
    write[k] = wr;
    addr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic run_until_ack(input int k);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m_ack == k) begin
        req[k] = 1'b0;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic step_agents();
    for (int k = 0; k < N; k++) begin
      case (ag[k])
        0: if ($urandom_range(0, 3) == 0) begin
          set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
          ag[k] = 1;
        end
        1: if (m_ack == k) begin
          if ($urandom_range(0, 1) == 0) begin
            req[k] = 1'b0;
            ag[k] = 0;
          end else begin
            set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end
        end else if (m_owner == k) begin
          if ($urandom_range(0, 7) == 0) begin
            req[k] = 1'b0;
            ag[k] = 2;
          end else if ($urandom_range(0, 1) == 0) begin
            addr[k*AW +: AW]  = $urandom;
            wdata[k*DW +: DW] = $urandom;
            write[k] = ~write[k];
          end
        end
        default: if (m_ack == k) ag[k] = 0;
      endcase
    end
  endtask

  int order [4] = '{0, 1, 0, 1};
  int n_acks;

  initial begin
    model_reset();
    for (int k = 0; k < N; k++) ag[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    tick();
    tick();

    // Single write from requester 0.
    set_req(0, 1'b1, 32'h0000_0010, 32'h0000_00A5);
    run_until_ack(0);
    tick();

    // Read from requester 1 with fixed slave data.
    prdata = 32'h1234_5678;
    set_req(1, 1'b0, 32'h0000_0020, 32'h0);
    run_until_ack(1);
    tick();

    // Both requesters held for four transfers: must alternate.
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    set_req(1, 1'b0, 32'h0000_0200, 32'h0);
    n_acks = 0;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      prdata = $urandom;
      tick();
      if (m_ack >= 0) begin
        check("rr_order", ack, oh(order[n_acks]));
        n_acks++;
        if (n_acks == 4) req = '0;
      end
    end
    check("rr_count", n_acks, 4);
    tick();

    // Reset during SETUP, pending request regranted afterwards.
    set_req(0, 1'b1, 32'h0000_0030, 32'h0000_0033);
    tick();
    pulse_reset();
    run_until_ack(0);
    tick();

    // Fields changed during SETUP and request dropped during ACCESS.
    prdata = 32'hCAFE_0001;
    set_req(0, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    addr[0 +: AW] = 32'h0000_0099;
    tick();
    req[0] = 1'b0;
    run_until_ack(0);
    tick();

`ifdef COUNTER_APB_ARB_PREADY_EN
    // Slave holds off three ACCESS cycles.
    pready = 1'b0;
    set_req(1, 1'b1, 32'h0000_0050, 32'h0000_0055);
    tick();
    tick();
    repeat (3) tick();
    pready = 1'b1;
    run_until_ack(1);
    tick();
`endif

    for (int c = 0; c < 3000; c++) begin
      prdata = $urandom;
`ifdef COUNTER_APB_ARB_PREADY_EN
      pready = ($urandom_range(0, 3) != 0);
`endif
      step_agents();
      if ($urandom_range(0, 499) == 0) pulse_reset();
      tick();
    end
    req = '0;
    pready = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
